// File: rtl/inst_fetch_queue_pkg.sv
// Shared types for the epoch-tagged instruction fetch queue.
package inst_fetch_queue_pkg;

  typedef logic [31:0] rvwordT;

  typedef enum logic [1:0] {
    EPOCH_RED     = 2'd0,
    EPOCH_GREEN   = 2'd1,
    EPOCH_INVALID = 2'd3
  } EpochT;

  typedef struct packed {
    rvwordT pc;
    rvwordT inst;
  } ifqEntryT;

  // INVALID maps to RED so a corrupted epoch register recovers to a legal value.
  function automatic EpochT flip_epoch(input EpochT e);
    case (e)
      EPOCH_RED:   return EPOCH_GREEN;
      EPOCH_GREEN: return EPOCH_RED;
      default:     return EPOCH_RED;
    endcase
  endfunction

endpackage

// File: rtl/inst_fetch_queue_if.sv
// Fetch-side enqueue and execute-side dequeue handshakes of the fetch queue.
interface inst_fetch_queue_if
  import inst_fetch_queue_pkg::*;
#(
  parameter int XLEN = 32
) ();

  logic            enq_valid;
  logic            enq_ready;
  logic [XLEN-1:0] enq_pc;
  logic [XLEN-1:0] enq_inst;
  EpochT           enq_epoch;
  logic            deq_valid;
  logic            deq_ready;
  logic [XLEN-1:0] deq_pc;
  logic [XLEN-1:0] deq_inst;

  modport master (
    output enq_valid, enq_pc, enq_inst, enq_epoch, deq_ready,
    input  enq_ready, deq_valid, deq_pc, deq_inst
  );

  modport slave (
    input  enq_valid, enq_pc, enq_inst, enq_epoch, deq_ready,
    output enq_ready, deq_valid, deq_pc, deq_inst
  );

endinterface

// File: rtl/inst_fetch_queue_ifq_ptr.sv
// Wrap-bit queue pointer with increment enable and a load path for flushes.
module ifq_ptr #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] ptr_o
);

  logic [W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (load_i)     ptr_d = load_val_i;
    else if (inc_i) ptr_d = ptr_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/inst_fetch_queue.sv
// Epoch-tagged fetch->execute instruction buffer; wrong-path returns are dropped.
// Define IFQ_BYPASS_EN for a zero-latency path through an empty queue.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32,
  parameter int CNTW  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  inst_fetch_queue_if.slave        bus,
  input  logic                     redirect,
  output EpochT                    cur_epoch,
  output logic [$clog2(DEPTH):0]   count,
  output logic [CNTW-1:0]          drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [XLEN-1:0] pc_q   [DEPTH];
  logic [XLEN-1:0] inst_q [DEPTH];
  EpochT           epoch_q, epoch_d;
  logic [CNTW-1:0] drop_q, drop_d;
  logic [CNTW:0]   drop_add, drop_sum;

  logic empty, full, epoch_ok, enq_fire, wr_en, stale, deq_fire, bypass_take;

  assign empty    = (rd_ptr == wr_ptr);
  assign full     = (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]) && (rd_ptr[AW] != wr_ptr[AW]);
  assign epoch_ok = (bus.enq_epoch == epoch_q);
  assign enq_fire = bus.enq_valid && !full && !redirect;
  assign stale    = enq_fire && !epoch_ok;
  assign deq_fire = !empty && bus.deq_ready;
  assign wr_en    = enq_fire && epoch_ok && !bypass_take;

`ifdef IFQ_BYPASS_EN
  logic bypass;
  assign bypass      = empty && bus.enq_valid && epoch_ok && !redirect;
  // A bypassed word consumed this cycle never touches storage.
  assign bypass_take = bypass && bus.deq_ready;
  assign bus.deq_valid = !empty || bypass;
  assign bus.deq_pc    = bypass ? bus.enq_pc   : pc_q[rd_ptr[AW-1:0]];
  assign bus.deq_inst  = bypass ? bus.enq_inst : inst_q[rd_ptr[AW-1:0]];
`else
  assign bypass_take   = 1'b0;
  assign bus.deq_valid = !empty;
  assign bus.deq_pc    = pc_q[rd_ptr[AW-1:0]];
  assign bus.deq_inst  = inst_q[rd_ptr[AW-1:0]];
`endif

  assign bus.enq_ready = !full;

  // Flush empties the queue by snapping the read pointer onto the write pointer.
  ifq_ptr #(.W(PW)) u_rd_ptr (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc_i      (deq_fire),
    .load_i     (redirect),
    .load_val_i (wr_ptr),
    .ptr_o      (rd_ptr)
  );

  ifq_ptr #(.W(PW)) u_wr_ptr (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc_i      (wr_en),
    .load_i     (1'b0),
    .load_val_i ({PW{1'b0}}),
    .ptr_o      (wr_ptr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        inst_q[i] <= '0;
      end
    end else if (wr_en) begin
      pc_q[wr_ptr[AW-1:0]]   <= bus.enq_pc;
      inst_q[wr_ptr[AW-1:0]] <= bus.enq_inst;
    end
  end

  always_comb begin
    epoch_d  = epoch_q;
    drop_add = '0;
    if (redirect) begin
      epoch_d  = flip_epoch(epoch_q);
      drop_add = (CNTW+1)'(count) + (CNTW+1)'(bus.enq_valid);
    end else if (stale) begin
      drop_add = (CNTW+1)'(1);
    end
    drop_sum = {1'b0, drop_q} + drop_add;
    drop_d   = drop_sum[CNTW] ? {CNTW{1'b1}} : drop_sum[CNTW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      epoch_q <= EPOCH_RED;
      drop_q  <= '0;
    end else begin
      epoch_q <= epoch_d;
      drop_q  <= drop_d;
    end
  end

  assign count     = wr_ptr - rd_ptr;
  assign cur_epoch = epoch_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed self-checking bench for inst_fetch_queue (DEPTH=4); honours IFQ_BYPASS_EN.
module tb_inst_fetch_queue;
  import inst_fetch_queue_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect = 1'b0;
  EpochT       cur_epoch;
  logic [2:0]  count;
  logic [15:0] drop_cnt;
  int          total = 0;
  int          bad = 0;

  inst_fetch_queue_if #(.XLEN(32)) bus ();

  inst_fetch_queue #(.DEPTH(4), .XLEN(32), .CNTW(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .redirect  (redirect),
    .cur_epoch (cur_epoch),
    .count     (count),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [31:0] pc, input EpochT ep);
    bus.enq_valid = v;
    bus.enq_pc    = pc;
    bus.enq_inst  = pc ^ 32'hA5A5_0000;
    bus.enq_epoch = ep;
  endtask

  initial begin
    offer(1'b0, 32'h0, EPOCH_RED);
    bus.deq_ready = 1'b0;
    #2;
    check("rst_count", 64'(count), 64'd0);
    check("rst_deq_valid", 64'(bus.deq_valid), 64'd0);
    check("rst_enq_ready", 64'(bus.enq_ready), 64'd1);
    check("rst_epoch", 64'(cur_epoch), 64'(EPOCH_RED));
    check("rst_drop", 64'(drop_cnt), 64'd0);
    check("rst_deq_pc", 64'(bus.deq_pc), 64'd0);
    #10 rst_n = 1'b1;
    tick();

    // fill to full with deq stalled
    for (int i = 0; i < 4; i++) begin
      offer(1'b1, 32'(4 * i), EPOCH_RED);
      tick();
    end
    check("fill_count", 64'(count), 64'd4);
    check("fill_enq_ready", 64'(bus.enq_ready), 64'd0);
    offer(1'b1, 32'h10, EPOCH_RED);
    tick();
    check("full_reject_count", 64'(count), 64'd4);
    check("full_reject_drop", 64'(drop_cnt), 64'd0);

    // drain in order
    offer(1'b0, 32'h0, EPOCH_RED);
    bus.deq_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("drain_valid", 64'(bus.deq_valid), 64'd1);
      check("drain_pc", 64'(bus.deq_pc), 64'(4 * i));
      check("drain_inst", 64'(bus.deq_inst), 64'((4 * i) ^ 32'hA5A5_0000));
      tick();
    end
    check("drain_count", 64'(count), 64'd0);
    check("drain_valid_end", 64'(bus.deq_valid), 64'd0);

    // streaming across the pointer wrap
    for (int i = 0; i < 10; i++) begin
      offer(1'b1, 32'(32'h200 + 4 * i), EPOCH_RED);
      #1;
`ifdef IFQ_BYPASS_EN
      check("wrap_byp_valid", 64'(bus.deq_valid), 64'd1);
      check("wrap_byp_pc", 64'(bus.deq_pc), 64'(32'h200 + 4 * i));
`else
      if (i > 0) begin
        check("wrap_valid", 64'(bus.deq_valid), 64'd1);
        check("wrap_pc", 64'(bus.deq_pc), 64'(32'h200 + 4 * (i - 1)));
      end else begin
        check("wrap_first_latency", 64'(bus.deq_valid), 64'd0);
      end
`endif
      tick();
      check("wrap_count_le1", 64'(count <= 3'd1), 64'd1);
    end
    offer(1'b0, 32'h0, EPOCH_RED);
`ifndef IFQ_BYPASS_EN
    #1;
    check("wrap_last_pc", 64'(bus.deq_pc), 64'h224);
`endif
    tick();
    check("wrap_end_count", 64'(count), 64'd0);

    // stale and invalid epochs are dropped
    bus.deq_ready = 1'b0;
    offer(1'b1, 32'h40, EPOCH_GREEN);
    tick();
    check("stale_count", 64'(count), 64'd0);
    check("stale_drop", 64'(drop_cnt), 64'd1);
    offer(1'b1, 32'h44, EPOCH_INVALID);
    tick();
    check("invalid_count", 64'(count), 64'd0);
    check("invalid_drop", 64'(drop_cnt), 64'd2);

    // redirect flush with three held entries plus an offered word
    for (int i = 0; i < 3; i++) begin
      offer(1'b1, 32'(32'h50 + 4 * i), EPOCH_RED);
      tick();
    end
    check("pre_flush_count", 64'(count), 64'd3);
    offer(1'b1, 32'h5C, EPOCH_RED);
    redirect = 1'b1;
    tick();
    redirect = 1'b0;
    offer(1'b0, 32'h0, EPOCH_GREEN);
    #1;
    check("flush_count", 64'(count), 64'd0);
    check("flush_epoch", 64'(cur_epoch), 64'(EPOCH_GREEN));
    check("flush_drop", 64'(drop_cnt), 64'd6);
    check("flush_deq_valid", 64'(bus.deq_valid), 64'd0);
    offer(1'b1, 32'h100, EPOCH_GREEN);
    tick();
    offer(1'b0, 32'h0, EPOCH_GREEN);
    #1;
    check("post_flush_valid", 64'(bus.deq_valid), 64'd1);
    check("post_flush_pc", 64'(bus.deq_pc), 64'h100);
    check("post_flush_count", 64'(count), 64'd1);

    // back-to-back redirects
    redirect = 1'b1;
    tick();
    check("b2b1_epoch", 64'(cur_epoch), 64'(EPOCH_RED));
    check("b2b1_drop", 64'(drop_cnt), 64'd7);
    tick();
    redirect = 1'b0;
    check("b2b2_epoch", 64'(cur_epoch), 64'(EPOCH_GREEN));
    check("b2b2_drop", 64'(drop_cnt), 64'd7);
    check("b2b2_count", 64'(count), 64'd0);

    // reset between edges with two entries held
    offer(1'b1, 32'h300, EPOCH_GREEN);
    tick();
    offer(1'b1, 32'h304, EPOCH_GREEN);
    tick();
    offer(1'b0, 32'h0, EPOCH_RED);
    check("pre_rst_count", 64'(count), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_deq_valid", 64'(bus.deq_valid), 64'd0);
    check("midrst_count", 64'(count), 64'd0);
    check("midrst_epoch", 64'(cur_epoch), 64'(EPOCH_RED));
    check("midrst_drop", 64'(drop_cnt), 64'd0);
    #1 rst_n = 1'b1;
    tick();

    // empty-queue latency: bypass or one cycle
    bus.deq_ready = 1'b1;
    offer(1'b1, 32'h20, EPOCH_RED);
    #1;
`ifdef IFQ_BYPASS_EN
    check("byp_valid", 64'(bus.deq_valid), 64'd1);
    check("byp_pc", 64'(bus.deq_pc), 64'h20);
    tick();
    offer(1'b0, 32'h0, EPOCH_RED);
    check("byp_count", 64'(count), 64'd0);
`else
    check("lat_same_cycle_valid", 64'(bus.deq_valid), 64'd0);
    tick();
    offer(1'b0, 32'h0, EPOCH_RED);
    check("lat_next_valid", 64'(bus.deq_valid), 64'd1);
    check("lat_next_pc", 64'(bus.deq_pc), 64'h20);
    check("lat_next_count", 64'(count), 64'd1);
    tick();
    check("lat_drained", 64'(count), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
